// File: rtl/uart_bus_master.sv
// uart_bus_master: decodes 8N1 UART host commands (three bytes each) into single writes on the peripheral write bus
module uart_bus_master #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [12:0] bus_wraddr,
  output logic [8:0]  bus_wrdata,
  output logic        bus_wrvalid,
  input  logic        bus_wrready,
  output logic        frame_err,
  output logic        overrun
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO);
  localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_M1 = TW'(TO - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {B0, B1, B2} cmd_state_t;
  logic rx_m, rx_s;
  rx_state_t rs, rs_n;
  logic [BW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic byte_valid, bv_n, fe_n;
  cmd_state_t ps, ps_n;
  logic [5:0] hi, hi_n;
  logic [7:0] lo, lo_n;
  logic [TW-1:0] to_cnt, to_n;
  logic load, ov_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end
  always_comb begin
    rs_n = rs;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    bv_n = 1'b0;
    fe_n = 1'b0;
    case (rs)
      IDLE: begin
        cnt_n = '0;
        rs_n = rx_s ? IDLE : START;
      end
      START: if (cnt == HALF_M1) begin
        cnt_n = '0;
        idx_n = '0;
        rs_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == FULL_M1) begin
        cnt_n = '0;
        sh_n = {rx_s, sh[7:1]};
        idx_n = idx + 1'b1;
        rs_n = (idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt == FULL_M1) begin
        cnt_n = '0;
        rs_n = IDLE;
        bv_n = rx_s;
        fe_n = !rx_s;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rs <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rs <= rs_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      byte_valid <= bv_n;
      frame_err <= fe_n;
    end
  end
  // the timeout measures the idle gap between bytes of a partial command
  always_comb begin
    ps_n = ps;
    hi_n = hi;
    lo_n = lo;
    load = 1'b0;
    ov_n = 1'b0;
    to_n = (byte_valid || ps == B0 || rs != IDLE) ? '0 : to_cnt + 1'b1;
    if (frame_err) ps_n = B0;
    else if (byte_valid) begin
      case (ps)
        B0: if (sh[7]) begin
          hi_n = sh[5:0];
          ps_n = B1;
        end
        B1: begin
          lo_n = sh;
          ps_n = B2;
        end
        default: begin
          ps_n = B0;
          load = !bus_wrvalid;
          ov_n = bus_wrvalid;
        end
      endcase
    end else if (ps != B0 && to_cnt == TO_M1) ps_n = B0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ps <= B0;
      hi <= '0;
      lo <= '0;
      to_cnt <= '0;
      bus_wrvalid <= 1'b0;
      bus_wraddr <= '0;
      bus_wrdata <= '0;
      overrun <= 1'b0;
    end else begin
      ps <= ps_n;
      hi <= hi_n;
      lo <= lo_n;
      to_cnt <= to_n;
      bus_wrvalid <= load || (bus_wrvalid && !bus_wrready);
      overrun <= ov_n;
      if (load) begin
        bus_wraddr <= {hi[4:0], lo};
        bus_wrdata <= {hi[5], sh};
      end
    end
  end
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed UART commands against a command-level write scoreboard
module tb_uart_bus_master;
  localparam int CPB = 8;
  localparam int TOB = 4;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, bus_wrready = 1'b1;
  logic [12:0] bus_wraddr;
  logic [8:0] bus_wrdata;
  logic bus_wrvalid, frame_err, overrun;
  int compared = 0, mismatched = 0;
  typedef struct packed {logic [12:0] a; logic [8:0] d;} wr_t;
  wr_t q[$];
  int stage = 0, gap = 0, exp_fe = 0, exp_ov = 0, fe_seen = 0, ov_seen = 0;
  logic [7:0] m_hi, m_lo;
  logic pv = 1'b0, r_edge;
  logic [12:0] pa;
  logic [8:0] pd;

  always #5 clk = ~clk;

  uart_bus_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .bus_wraddr(bus_wraddr), .bus_wrdata(bus_wrdata), .bus_wrvalid(bus_wrvalid),
    .bus_wrready(bus_wrready), .frame_err(frame_err), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // command-level model: a completed command is either queued or counted as an overrun
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_fe++;
      stage = 0;
    end else if (stage == 0) begin
      if (b[7]) begin m_hi = b; stage = 1; end
    end else if (stage == 1) begin
      m_lo = b;
      stage = 2;
    end else begin
      stage = 0;
      if (q.size() != 0) exp_ov++;
      else q.push_back({m_hi[4:0], m_lo, m_hi[5], b});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    gap += n;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok = 1'b1);
    if (gap >= CPB * TOB) stage = 0;
    gap = 0;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    model_byte(b, ok);
    rx = ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx = 1'b1;
    q.delete();
    stage = 0;
    gap = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic end_test(input string name);
    check({name, "_writes_left"}, 32'(q.size()), 0);
    check({name, "_frame_err"}, 32'(fe_seen), 32'(exp_fe));
    check({name, "_overrun"}, 32'(ov_seen), 32'(exp_ov));
  endtask

  task automatic check_wr(input string name, input logic [12:0] a, input logic [8:0] d);
    check({name, "_valid"}, 32'(bus_wrvalid), 1);
    check({name, "_addr"}, 32'(bus_wraddr), 32'(a));
    check({name, "_data"}, 32'(bus_wrdata), 32'(d));
  endtask

  always begin
    @(posedge clk);
    r_edge = bus_wrready;
    #1;
    if (rst) pv = 1'b0;
    else begin
      if (pv && r_edge) begin
        check("valid_drop", 32'(bus_wrvalid), 0);
        if (q.size() != 0) void'(q.pop_front());
      end else if (pv) begin
        check("hold_valid", 32'(bus_wrvalid), 1);
        check("hold_addr", 32'(bus_wraddr), 32'(pa));
        check("hold_data", 32'(bus_wrdata), 32'(pd));
      end
      if (bus_wrvalid) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus_wraddr, bus_wrdata);
        end else begin
          check("wr_addr", 32'(bus_wraddr), 32'(q[0].a));
          check("wr_data", 32'(bus_wrdata), 32'(q[0].d));
        end
      end
      fe_seen += int'(frame_err);
      ov_seen += int'(overrun);
      pv = bus_wrvalid;
      pa = bus_wraddr;
      pd = bus_wrdata;
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus_wrvalid), 0);
    check("rst_addr", 32'(bus_wraddr), 0);
    check("rst_data", 32'(bus_wrdata), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    idle(20);
    send_byte(8'hA1); send_byte(8'h23); send_byte(8'h45);
    check_wr("t1", 13'h0123, 9'h145);
    @(negedge clk);
    check("t1_one_cycle", 32'(bus_wrvalid), 0);
    idle(60);
    end_test("t1");
    send_byte(8'h05); send_byte(8'h80); send_byte(8'h00); send_byte(8'h07);
    check_wr("t2", 13'h0000, 9'h007);
    idle(60);
    end_test("t2");
    bus_wrready = 1'b0;
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h02);
    idle(20);
    check_wr("t3_held", 13'h0000, 9'h001);
    check("t3_overrun_once", 32'(ov_seen), 1);
    bus_wrready = 1'b1;
    idle(20);
    check("t3_released", 32'(bus_wrvalid), 0);
    end_test("t3");
    send_byte(8'h9F); send_byte(8'hFF);
    idle(40);
    send_byte(8'h80); send_byte(8'h10); send_byte(8'h0A);
    check_wr("t4", 13'h0010, 9'h00A);
    idle(60);
    end_test("t4");
    send_byte(8'h80, 1'b0);
    idle(16);
    send_byte(8'hFF); send_byte(8'h01);
    idle(60);
    check("t5_frame_err_once", 32'(fe_seen), 1);
    end_test("t5");
    bus_wrready = 1'b0;
    send_byte(8'h81); send_byte(8'h22); send_byte(8'h33);
    idle(5);
    check_wr("t6_pending", 13'h0122, 9'h033);
    send_byte(8'h80);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (CPB) @(negedge clk);
    end
    do_reset();
    check("t6_rst_valid", 32'(bus_wrvalid), 0);
    check("t6_rst_addr", 32'(bus_wraddr), 0);
    check("t6_rst_data", 32'(bus_wrdata), 0);
    check("t6_rst_frame_err", 32'(frame_err), 0);
    check("t6_rst_overrun", 32'(overrun), 0);
    bus_wrready = 1'b1;
    idle(20);
    send_byte(8'h80); send_byte(8'h01); send_byte(8'h02);
    check_wr("t6", 13'h0001, 9'h002);
    idle(60);
    end_test("t6");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Serial-to-bus bridge that decodes 8N1 UART frames from a host and issues single write transactions on the peripheral write bus (13-bit address, 9-bit data, valid/ready). It sits upstream of the bus peripherals (LED register, etc.) and is the only write master on that bus. Each host command is three bytes and becomes exactly one bus write.

## Interface
Parameters:
- CLKS_PER_BIT, default 434: clk cycles per UART bit (50 MHz / 115200); must be >= 4.
- TIMEOUT_BITS, default 20: inter-byte idle gap, in bit times, that aborts a partial command.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  UART receive line, asynchronous, idle high.
- bus_wraddr  out  13  write address.
- bus_wrdata  out  9  write data.
- bus_wrvalid  out  1  write request.
- bus_wrready  in  1  write accepted by the peripheral when high with bus_wrvalid.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: command completed while a write was still pending; command dropped.

## Operation
- rx passes through a 2-flop synchronizer; both flops reset to 1.
- Receiver FSM: IDLE, START, DATA, STOP.
  - IDLE: synchronized rx low -> START, counter cleared.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample rx; low -> DATA; high -> IDLE (glitch, no error).
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. High -> byte_valid for one cycle, go to IDLE. Low -> frame_err pulse, byte discarded, parser forced to B0, go to IDLE.
- Command parser: B0, B1, B2.
  - B0 byte: bit7 must be 1 (marker), bit6 ignored, bit5 = data[8], bits4:0 = addr[12:8]. If bit7 = 0, the byte is discarded and the parser stays in B0.
  - B1 byte: addr[7:0].
  - B2 byte: data[7:0]. Command completes.
- On completion with bus_wrvalid low: load bus_wraddr and bus_wrdata and set bus_wrvalid.
- On completion with bus_wrvalid high: outputs are unchanged, overrun pulses, command dropped.
- bus_wrvalid clears on the cycle after a clock edge with bus_wrvalid && bus_wrready.
- While bus_wrvalid is high, bus_wraddr and bus_wrdata are held stable.
- Timeout: while the parser is in B1 or B2, count cycles since the last byte_valid. At TIMEOUT_BITS*CLKS_PER_BIT cycles the parser returns to B0. The count is reset on every byte_valid.
- Reset, including mid-byte or mid-command: receiver to IDLE, parser to B0, and all counters cleared. bus_wrvalid=0, bus_wraddr=0, bus_wrdata=0, frame_err=0, overrun=0. A write pending at reset is lost.

## Timing
- byte_valid is asserted on the cycle after the stop-bit sample edge.
- bus_wrvalid rises on the cycle after byte_valid for B2.
- The earliest bus_wrvalid is 2 cycles after the stop-bit sample, excluding the 2-cycle synchronizer delay.
- bus_wrready may be tied high. The write then lasts exactly one cycle, and the next command can load on any later cycle.
- When a completion and a bus_wrvalid&&bus_wrready handshake fall on the same edge, the completion sees the old bus_wrvalid=1: overrun pulses and the command is dropped.
- frame_err and overrun are single-cycle pulses, registered, with no combinational path from rx.
- Receiver sampling is not blocked by backpressure; bytes keep arriving regardless of bus_wrready.

## Test plan
All tests use CLKS_PER_BIT=8, TIMEOUT_BITS=4, bus_wrready=1 unless stated.
- Send 0xA1, 0x23, 0x45 -> one-cycle bus_wrvalid with addr=0x0123, data=0x145; frame_err=0, overrun=0.
- Send 0x05, then 0x80, 0x00, 0x07 -> 0x05 is ignored; exactly one write with addr=0x0000, data=0x007.
- Hold bus_wrready=0, send 0x80,0x00,0x01 then 0x80,0x00,0x02 -> write 1 is held stable; overrun pulses once at the second completion; releasing ready completes only data=0x001.
- Send 0x9F, 0xFF, wait 40 cycles idle, then send 0x80, 0x10, 0x0A -> timeout discards the partial command; write addr=0x0010, data=0x00A.
- Send 0x80 with its stop bit driven low, then 0xFF, 0x01 -> frame_err pulses once; 0xFF is taken as B0, so the command is still incomplete and no write occurs.
- Assert rst for 1 cycle midway through the data bits of B1 -> all outputs read 0; a new complete command 0x80,0x01,0x02 writes addr=0x0001, data=0x002.
